// File: rtl/exec_seq_pkg.sv
// Shared encodings for the Execute-stage sequencer: FSM states, request kinds,
// aluMux selects and the ALU opcodes the sequencer issues on its own.
package exec_seq_pkg;

    typedef logic [2:0] seqState_t;

    localparam seqState_t ST_IDLE = 3'd0;
    localparam seqState_t ST_ALU  = 3'd1;
    localparam seqState_t ST_CMP  = 3'd2;
    localparam seqState_t ST_MUL  = 3'd3;
    localparam seqState_t ST_RESP = 3'd4;

    localparam logic [1:0] KIND_ALU = 2'b00;
    localparam logic [1:0] KIND_CMP = 2'b01;
    localparam logic [1:0] KIND_MUL = 2'b10;
    localparam logic [1:0] KIND_RSV = 2'b11;

    localparam logic [1:0] MUX_REG  = 2'b00;
    localparam logic [1:0] MUX_IMM  = 2'b01;
    localparam logic [1:0] MUX_ZERO = 2'b10;

    // Must match the ALU decoder's encodings for add and subtract.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

endpackage

// File: rtl/exec_sequencer_mul.sv
// Shift-add multiplier state: accumulator, shifting multiplicand and multiplier.
// The add itself is done by the external ALU; its sum comes back on sum.
module mul_datapath #(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [DBITS-1:0] loadMcand,
    input  logic [DBITS-1:0] loadMplier,
    input  logic [DBITS-1:0] sum,
    output logic [DBITS-1:0] acc,
    output logic [DBITS-1:0] mcand,
    output logic [DBITS-1:0] mplier
);

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values of the others; blocking here would chain acc/mcand/mplier.
    // NOTE: these registers are reset so an aborted multiply leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= loadMcand;
            mplier <= loadMplier;
        end else if (step) begin
            if (mplier[0])
                acc <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer feeding the Execute stage: single-cycle ALU ops,
// branch compares and shift-add multiplies, one outstanding request at a time.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int OPCODE_BIT_WIDTH = 4,
    parameter int DBITS            = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_kind,
    input  logic [OPCODE_BIT_WIDTH-1:0] req_op,
    input  logic [1:0]                  req_src,
    input  logic [DBITS-1:0]            req_a,
    input  logic [DBITS-1:0]            req_b,
    input  logic [DBITS-1:0]            req_imm,
    output logic [DBITS-1:0]            ex_reg1,
    output logic [DBITS-1:0]            ex_reg2,
    output logic [DBITS-1:0]            ex_imm,
    output logic [1:0]                  ex_alumux,
    output logic [OPCODE_BIT_WIDTH-1:0] ex_opalu,
    output logic [3:0]                  ex_opcond,
    input  logic [DBITS-1:0]            ex_outalu,
    input  logic                        ex_outcond,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DBITS-1:0]            rsp_data,
    output logic                        rsp_taken,
    output logic                        busy
);

    seqState_t                   state;
    logic [OPCODE_BIT_WIDTH-1:0] opReg;
    logic [1:0]                  srcReg;
    logic [DBITS-1:0]            aReg, bReg, immReg;
    logic [DBITS-1:0]            rspData;
    logic                        rspTaken;
    logic [DBITS-1:0]            acc, mcand, mplier;
    logic                        mulLoad, mulStep;

    assign mulLoad = (state == ST_IDLE) && req_valid && (req_kind == KIND_MUL);
    assign mulStep = (state == ST_MUL) && (mplier != '0);

    mul_datapath #(.DBITS(DBITS)) mulDp (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (mulLoad),
        .step       (mulStep),
        .loadMcand  (req_a),
        .loadMplier ((req_src == MUX_IMM) ? req_imm : req_b),
        .sum        (ex_outalu),
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            opReg    <= '0;
            srcReg   <= MUX_REG;
            aReg     <= '0;
            bReg     <= '0;
            immReg   <= '0;
            rspData  <= '0;
            rspTaken <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    opReg  <= req_op;
                    srcReg <= req_src;
                    aReg   <= req_a;
                    bReg   <= req_b;
                    immReg <= req_imm;
                    case (req_kind)
                        KIND_ALU: state <= ST_ALU;
                        KIND_CMP: state <= ST_CMP;
                        KIND_MUL: state <= ST_MUL;
                        default: begin
                            rspData  <= '0;
                            rspTaken <= 1'b0;
                            state    <= ST_RESP;
                        end
                    endcase
                end
                ST_ALU: begin
                    rspData  <= ex_outalu;
                    rspTaken <= 1'b0;
                    state    <= ST_RESP;
                end
                ST_CMP: begin
                    rspData  <= ex_outalu;
                    rspTaken <= ex_outcond;
                    state    <= ST_RESP;
                end
                ST_MUL: if (mplier == '0) begin
                    rspData  <= acc;
                    rspTaken <= 1'b0;
                    state    <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        ex_reg1   = '0;
        ex_reg2   = '0;
        ex_imm    = '0;
        ex_alumux = MUX_REG;
        ex_opalu  = OPCODE_BIT_WIDTH'(OP_ADD);
        ex_opcond = 4'd0;
        case (state)
            ST_ALU, ST_CMP: begin
                ex_reg1   = aReg;
                ex_reg2   = bReg;
                ex_imm    = immReg;
                ex_alumux = srcReg;
                ex_opalu  = (state == ST_CMP) ? OPCODE_BIT_WIDTH'(OP_SUB) : opReg;
                ex_opcond = (state == ST_CMP) ? opReg[3:0] : 4'd0;
            end
            ST_MUL: begin
                ex_reg1 = acc;
                ex_reg2 = mcand;
            end
            default: ;
        endcase
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_data  = rspData;
    assign rsp_taken = rspTaken;

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle sequencer in front of the Execute stage (ALU + ConditionalCheck). Accepts one decoded operation at a time over a valid/ready request port and drives Execute's operand, mux and opcode inputs. Runs single-cycle ALU ops, branch compares (subtract + condition), and shift-add multiplies that reuse the ALU adder over several cycles. Returns one result per request over a valid/ready response port.

## Interface
- OPCODE_BIT_WIDTH, 4, width of ALU opcode
- DBITS, 32, datapath width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer accepts request (high only in IDLE)
- req_kind  in  2  00 ALU, 01 compare, 10 multiply, 11 reserved
- req_op  in  OPCODE_BIT_WIDTH  ALU opcode (kind 00) or condition code in [3:0] (kind 01)
- req_src  in  2  aluMux value: 00 reg, 01 imm, 10 zero
- req_a, req_b, req_imm  in  DBITS each  operands
- ex_reg1, ex_reg2, ex_imm  out  DBITS each  to Execute inReg1/inReg2/imm32
- ex_alumux  out  2  to Execute aluMux
- ex_opalu  out  OPCODE_BIT_WIDTH  to Execute opAlu
- ex_opcond  out  4  to ConditionalCheck opCond
- ex_outalu  in  DBITS  Execute result
- ex_outcond  in  1  ConditionalCheck result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DBITS  result
- rsp_taken  out  1  compare outcome (0 for non-compare)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ALU, CMP, MUL, RESP. Registered state and operand/result registers.
- IDLE: req_ready=1. On req_valid: capture req_*; kind 00 -> ALU, 01 -> CMP, 10 -> MUL (acc=0, mcand=req_a, mplier = req_src==01 ? req_imm : req_b), 11 -> RESP with rsp_data=0, rsp_taken=0.
- ALU (1 cycle): ex_reg1=a, ex_reg2=b, ex_imm=imm, ex_alumux=src, ex_opalu=op; rsp_data<=ex_outalu, rsp_taken<=0; -> RESP.
- CMP (1 cycle): as ALU but ex_opalu=OP_SUB, ex_opcond=op[3:0]; rsp_data<=ex_outalu, rsp_taken<=ex_outcond; -> RESP.
- MUL (per cycle): if mplier==0: rsp_data<=acc, rsp_taken<=0, -> RESP. Else ex_reg1=acc, ex_reg2=mcand, ex_alumux=00, ex_opalu=OP_ADD; acc<=mplier[0] ? ex_outalu : acc; mcand<<=1; mplier>>=1 (logical). Product is low DBITS bits, unsigned, wraps.
- RESP: rsp_valid=1, rsp_data/rsp_taken stable; on rsp_ready -> IDLE.
- Outside ALU/CMP/MUL: ex_reg1/reg2/imm=0, ex_alumux=00, ex_opalu=OP_ADD, ex_opcond=0.
- No new request accepted before the response handshake completes (one outstanding op).

## Timing
- Reset (reset_n=0 at an edge): state IDLE, rsp_valid=0, rsp_data=0, rsp_taken=0, acc/mcand/mplier=0; req_ready=1 and busy=0 from the next cycle. Reset in any state aborts the op; no response emitted.
- ALU/CMP: accept at edge N, rsp_valid high from cycle N+2.
- Reserved kind: rsp_valid from N+1.
- MUL: occupies k+1 cycles, k = index of multiplier MSB set +1 (k=0 for zero multiplier); max DBITS+1. rsp_valid at N+k+2.
- req_ready, busy, rsp_valid, ex_* are decoded from registered state only (no combinational path from req_valid/rsp_ready).
- rsp_valid and rsp_ready both high at edge -> IDLE next cycle; earliest back-to-back accept is the following edge.

## Structure
- Package exec_seq_pkg: state enum, req_kind encodings (KIND_ALU, KIND_CMP, KIND_MUL, KIND_RSV), aluMux encodings, OP_ADD and OP_SUB opcode constants shared with the ALU decoder.
- Single module; optional sub-module mul_datapath holding acc/mcand/mplier registers and shift logic. Execute is instantiated outside, not inside.

## Test plan
- ALU: kind 00, op=OP_ADD, src=01, a=5, imm=10 -> rsp_valid at N+2, rsp_data=15, rsp_taken=0.
- Compare: kind 01, cond=equal, src=00, a=b=9 -> ex_opalu=OP_SUB in CMP cycle, rsp_data=0, rsp_taken=1.
- Multiply: a=6, b=7 -> 3 add cycles + 1 terminate, rsp_valid at N+5, rsp_data=42; a=6, b=0 -> rsp_valid at N+2, rsp_data=0; a=0xFFFFFFFF, b=2 -> rsp_data=0xFFFFFFFE.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0, new req_valid ignored; release -> IDLE next cycle.
- Reset mid-multiply (b=0x80000000, reset_n low at cycle 10) -> no response, req_ready=1, busy=0 after reset; next ALU op completes normally.
- Reserved kind 11 -> rsp_valid at N+1, rsp_data=0, rsp_taken=0.
